// File: rtl/fifo_pkg.sv
// Shared defaults and the pointer-advance helper for the FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Advance a circular-buffer pointer, wrapping at depth-1 so that
  // non-power-of-two depths work.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: one write port and one registered read port.
// The array itself has no reset; only the read-data register does.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: store the pushed word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: capture the popped word; holds between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty flags, registered read data with a valid strobe, and
// sticky overflow/underflow error flags.
//
// Handshake: a push is taken when wr_en & wr_ready, a pop when
// rd_en & rd_val. wr_ready and rd_val depend only on the registered
// count, never on wr_en/rd_en, so a full FIFO refuses a push even if a
// pop happens in the same cycle, and an empty FIFO refuses a pop even if
// a push happens in the same cycle.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AFULL_LVL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  parameter int PTR_W      = $clog2(FIFO_DEPTH),
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic                  rd_val,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_val,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_data_val_q, rd_data_val_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push, pop;

  // Status flags come from the registered count only.
  always_comb begin
    wr_ready     = (count_q < DEPTH_C);
    rd_val       = (count_q != '0);
    almost_full  = (count_q >= AFULL_C);
    almost_empty = (count_q <= AEMPTY_C);
  end

  assign push = wr_en & wr_ready;
  assign pop  = rd_en & rd_val;

  // Next-state: pointers, occupancy, read strobe and sticky error flags.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rd_data_val_d = pop;
    overflow_d    = overflow_q  | (wr_en & ~wr_ready);
    underflow_d   = underflow_q | (rd_en & ~rd_val);
    if (push) wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), FIFO_DEPTH));
    if (pop)  rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), FIFO_DEPTH));
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all contents immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_data_val_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_data_val_q <= rd_data_val_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign count       = count_q;
  assign rd_data_val = rd_data_val_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
